music_addr_seq: RTL and testbench

Playback sequencer between the mode-select state controller and the tone generator. It walks the song ROM from `start_addr` to `end_addr` and wraps back to the start. Each ROM word is held for its encoded number of beats. The current tone code goes downstream to the frequency divider. Playback restarts from `start_addr` whenever the controller's `cstate` changes.

---
 rtl/music_pkg.sv | 29 ++
 rtl/beat_gen.sv | 31 +++
 rtl/music_addr_seq.sv | 131 +++++++++++++
 tb/tb_music_addr_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared definitions for the music playback path: mode codes, ROM word layout,
// sequencer FSM encoding and the rest tone code.
// Imported by the sequencer and by anything that decodes song ROM words.
package music_pkg;

  // Mode codes driven by the state controller
  localparam logic [3:0] STATE1 = 4'd1;
  localparam logic [3:0] STATE2 = 4'd2;
  localparam logic [3:0] STATE3 = 4'd3;

  // Song ROM word layout: {duration in beats, tone code}
  localparam int DUR_MSB = 11;
  localparam int DUR_LSB = 8;
  localparam int DUR_W   = DUR_MSB - DUR_LSB + 1;
  localparam int TONE_W  = 8;
  localparam int WORD_W  = DUR_MSB + 1;

  localparam logic [TONE_W-1:0] TONE_REST = '0;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    ST_RESTART = 3'd0,
    ST_FETCH   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_PLAY    = 3'd3,
    ST_GAP     = 3'd4
  } seq_state_t;

endpackage

// File: rtl/beat_gen.sv
// Beat divider: one-cycle beat_tick every BEAT_DIV cycles counted from the last clr.
// Latency: beat_tick is decoded combinationally from the count register.
// Synchronous clr restarts the count so a beat never straddles two notes.
module beat_gen #(
  parameter int BEAT_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic beat_tick
);

  localparam int CW = (BEAT_DIV > 2) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEAT_DIV - 1);

  logic [CW-1:0] cnt;

  assign beat_tick = (cnt == LAST);

  // Free-running modulo-BEAT_DIV counter with synchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || beat_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/music_addr_seq.sv
// Song playback sequencer: walks ROM start_addr..end_addr, holds each word dur beats, wraps.
// Latency: rom_addr 2 cycles and tone 3 cycles after a restart begins; tone changes dur*BEAT_DIV+2 apart.
// No backpressure; a cstate change forces a restart on the next cycle. MUSIC_REST_GAP_EN adds a 1-beat rest.
module music_addr_seq
  import music_pkg::*;
#(
  parameter int BEAT_DIV = 12_500_000,
  parameter int AW       = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        cstate,
  input  logic [AW-1:0]     start_addr,
  input  logic [AW-1:0]     end_addr,
  output logic [AW-1:0]     rom_addr,
  input  logic [WORD_W-1:0] rom_q,
  output logic [TONE_W-1:0] tone,
  output logic              note_start,
  output logic              beat_tick
);

  seq_state_t        state, state_nxt;
  logic [AW-1:0]     cur_addr, cur_addr_nxt;
  logic [AW-1:0]     rom_addr_nxt;
  logic [AW-1:0]     next_addr;
  logic [TONE_W-1:0] tone_nxt;
  logic [DUR_W-1:0]  dur_cnt, dur_cnt_nxt;
  logic [DUR_W-1:0]  rom_dur;
  logic              note_start_nxt;
  logic [3:0]        cstate_q;
  logic              restart;
  logic              clr;

  // A mode change seen in any state pre-empts whatever that state would do
  assign restart = (cstate != cstate_q);

  // Wrap when at or past the end; this also covers start_addr > end_addr
  assign next_addr = (cur_addr >= end_addr) ? start_addr : cur_addr + AW'(1);

  assign rom_dur = rom_q[DUR_MSB:DUR_LSB];

  beat_gen #(
    .BEAT_DIV (BEAT_DIV)
  ) u_beat_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .beat_tick (beat_tick)
  );

  // State, address, tone and duration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RESTART;
      cur_addr   <= '0;
      rom_addr   <= '0;
      tone       <= TONE_REST;
      dur_cnt    <= '0;
      note_start <= 1'b0;
      cstate_q   <= '0;
    end else begin
      state      <= state_nxt;
      cur_addr   <= cur_addr_nxt;
      rom_addr   <= rom_addr_nxt;
      tone       <= tone_nxt;
      dur_cnt    <= dur_cnt_nxt;
      note_start <= note_start_nxt;
      cstate_q   <= cstate;
    end
  end

  // Next-state and datapath decisions; restart overrides advance, beat and load
  always_comb begin
    state_nxt      = state;
    cur_addr_nxt   = cur_addr;
    rom_addr_nxt   = rom_addr;
    tone_nxt       = tone;
    dur_cnt_nxt    = dur_cnt;
    note_start_nxt = 1'b0;
    clr            = 1'b0;
    if (restart) begin
      state_nxt = ST_RESTART;
    end else begin
      case (state)
        ST_RESTART: begin
          cur_addr_nxt = start_addr;
          clr          = 1'b1;
          state_nxt    = ST_FETCH;
        end
        ST_FETCH: begin
          rom_addr_nxt = cur_addr;
          state_nxt    = ST_LOAD;
        end
        ST_LOAD: begin
          tone_nxt       = rom_q[TONE_W-1:0];
          dur_cnt_nxt    = (rom_dur == '0) ? DUR_W'(1) : rom_dur;
          note_start_nxt = 1'b1;
          clr            = 1'b1;
          state_nxt      = ST_PLAY;
        end
        ST_PLAY: begin
          if (beat_tick) begin
            if (dur_cnt <= DUR_W'(1)) begin
              cur_addr_nxt = next_addr;
`ifdef MUSIC_REST_GAP_EN
              tone_nxt     = TONE_REST;
              clr          = 1'b1;
              state_nxt    = ST_GAP;
`else
              state_nxt    = ST_FETCH;
`endif
            end else begin
              dur_cnt_nxt = dur_cnt - DUR_W'(1);
            end
          end
        end
`ifdef MUSIC_REST_GAP_EN
        ST_GAP: begin
          if (beat_tick) begin
            state_nxt = ST_FETCH;
          end
        end
`endif
        default: begin
          state_nxt = ST_RESTART;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_music_addr_seq.sv
// Self-checking bench for music_addr_seq with BEAT_DIV = 4 and a 1-cycle ROM.
// Expected outputs come from an event-time model: note boundaries are scheduled arithmetically.
// Directed scenarios first, then randomized mode/range changes.
module tb_music_addr_seq;
  import music_pkg::*;

  localparam int BD = 4;
  localparam int AW = 10;

  logic              clk;
  logic              rst_n;
  logic [3:0]        cstate;
  logic [AW-1:0]     start_addr;
  logic [AW-1:0]     end_addr;
  logic [AW-1:0]     rom_addr;
  logic [WORD_W-1:0] rom_q;
  logic [TONE_W-1:0] tone;
  logic              note_start;
  logic              beat_tick;

  logic [WORD_W-1:0] mem [0:(1<<AW)-1];

  int errors = 0;
  int checks = 0;

  // model state (edge-count based schedule)
  int            cyc;
  int            ev_restart, ev_fetch, ev_load, ev_adv;
  int            last_clr;
  logic [3:0]    m_q;
  logic [AW-1:0] m_cur;
  logic [AW-1:0] exp_rom;
  logic [7:0]    exp_tone;
  logic          exp_ns;

  music_addr_seq #(.BEAT_DIV(BD), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cstate     (cstate),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .tone       (tone),
    .note_start (note_start),
    .beat_tick  (beat_tick)
  );

  assign rom_q = mem[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc        = 0;
    ev_restart = 1;
    ev_fetch   = 2;
    ev_load    = 3;
    ev_adv     = -1;
    last_clr   = 0;
    m_q        = '0;
    m_cur      = '0;
    exp_rom    = '0;
    exp_tone   = '0;
    exp_ns     = 1'b0;
  endtask

  // Advance the model to the edge just taken, using the inputs that were stable before it
  task automatic model_edge();
    int d;
    logic [WORD_W-1:0] w;
    exp_ns = 1'b0;
    if (cstate != m_q) begin
      ev_restart = cyc + 1;
      ev_fetch   = cyc + 2;
      ev_load    = cyc + 3;
      ev_adv     = -1;
    end else begin
      if (cyc == ev_restart) begin
        m_cur    = start_addr;
        last_clr = cyc;
      end
      if (cyc == ev_fetch) exp_rom = m_cur;
      if (cyc == ev_load) begin
        w        = mem[exp_rom];
        d        = (w[11:8] == 0) ? 1 : int'(w[11:8]);
        exp_tone = w[7:0];
        exp_ns   = 1'b1;
        last_clr = cyc;
        ev_adv   = cyc + d * BD;
      end
      if (cyc == ev_adv) begin
        m_cur = (m_cur >= end_addr) ? start_addr : m_cur + 1'b1;
`ifdef MUSIC_REST_GAP_EN
        exp_tone = 8'h00;
        last_clr = cyc;
        ev_fetch = cyc + BD + 1;
        ev_load  = cyc + BD + 2;
`else
        ev_fetch = cyc + 1;
        ev_load  = cyc + 2;
`endif
      end
    end
    m_q = cstate;
  endtask

  task automatic check_all();
    chk("rom_addr", 32'(rom_addr), 32'(exp_rom));
    chk("tone", 32'(tone), 32'(exp_tone));
    chk("note_start", 32'(note_start), 32'(exp_ns));
    chk("beat_tick", 32'(beat_tick), 32'(((cyc - last_clr) % BD) == BD - 1));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      model_edge();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] nc;
    rst_n      = 1'b0;
    cstate     = 4'd0;
    start_addr = '0;
    end_addr   = 10'd2;
    for (int i = 0; i < (1 << AW); i++) mem[i] = {4'($urandom_range(0, 3)), 8'($urandom)};
    model_reset();

    // Reset, first fetch, wrap over 0..2 and a zero-duration word
    mem[0] = {4'd2, 8'h11};
    mem[1] = {4'd0, 8'h33};
    mem[2] = {4'd1, 8'h44};
    do_reset();
    step(3);
    chk("first_tone", 32'(tone), 32'h11);
    chk("first_note_start", 32'(note_start), 32'h1);
    step(45);

    // Range change without a mode change: takes effect at next wrap
    end_addr = 10'd1;
    step(30);

    // Mode change mid-note to a far range
    cstate     = STATE1;
    start_addr = 10'd0;
    end_addr   = 10'd138;
    mem[0]     = {4'd8, 8'h5A};
    mem[139]   = {4'd1, 8'h77};
    step(15);
    cstate     = STATE2;
    start_addr = 10'd139;
    end_addr   = 10'd335;
    step(3);
    chk("restart_rom_addr", 32'(rom_addr), 32'd139);
    step(1);
    chk("restart_tone", 32'(tone), 32'h77);
    step(20);

    // Degenerate range replays start word
    cstate     = STATE3;
    start_addr = 10'd5;
    end_addr   = 10'd3;
    mem[5]     = {4'd1, 8'h66};
    step(30);
    chk("degen_rom_addr", 32'(rom_addr), 32'd5);

    // Repeated identical notes (rest gap articulation when enabled)
    cstate     = STATE1;
    start_addr = 10'd10;
    end_addr   = 10'd11;
    mem[10]    = {4'd1, 8'h22};
    mem[11]    = {4'd1, 8'h22};
    step(30);

    // Asynchronous reset mid-note
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rom_addr", 32'(rom_addr), 32'd0);
    chk("arst_tone", 32'(tone), 32'd0);
    chk("arst_note_start", 32'(note_start), 32'd0);
    chk("arst_beat_tick", 32'(beat_tick), 32'd0);
    for (int i = 0; i < 16; i++) mem[i] = {4'($urandom_range(0, 3)), 8'($urandom)};
    start_addr = 10'd0;
    end_addr   = 10'd3;
    do_reset();
    step(10);

    // Randomized mode and range changes, including restarts during fetch/load
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        nc = 4'($urandom_range(1, 3));
        if (nc == cstate) nc = (cstate == 4'd3) ? 4'd1 : cstate + 4'd1;
        cstate     = nc;
        start_addr = 10'($urandom_range(0, 15));
        end_addr   = 10'($urandom_range(0, 15));
      end else if ($urandom_range(0, 49) == 0) begin
        end_addr = 10'($urandom_range(0, 15));
      end
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
